// File: rtl/rcv_pkg.sv
// Shared types and default sizing for the UART receive control stage.
package rcv_pkg;

  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int NUM_BITS_DEF     = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    RECV      = 2'd2,
    STOP_CHK  = 2'd3
  } rcv_state_t;

  // Observation bundle: current state plus both counters, zero-extended to 8 bits.
  typedef struct packed {
    rcv_state_t  state;
    logic [7:0]  clk_cnt;
    logic [7:0]  bit_cnt;
  } rcv_dbg_t;

endpackage

// File: rtl/rcv_ctrl_if.sv
// Signal bundle between the receive controller and its surroundings
// (raw line in, shift-register MSB in, strobes/flags out, debug view out).
interface rcv_ctrl_if;
  import rcv_pkg::*;

  // Handshake semantics: there is no back-pressure. shift_strobe and
  // load_buffer are single-cycle pulses that the consumer must accept in the
  // cycle they are high (shift register shifts on shift_strobe, RX buffer
  // captures packet_data on load_buffer). framing_error is a level that stays
  // set until the next accepted start bit. rx_busy is a level.
  logic       serial_in;
  logic       stop_bit;
  logic       serial_sync;
  logic       shift_strobe;
  logic       load_buffer;
  logic       framing_error;
  logic       rx_busy;
  rcv_dbg_t   dbg;

  modport master (
    output serial_in, stop_bit,
    input  serial_sync, shift_strobe, load_buffer, framing_error, rx_busy, dbg
  );

  modport slave (
    input  serial_in, stop_bit,
    output serial_sync, shift_strobe, load_buffer, framing_error, rx_busy, dbg
  );

endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear. Counts 0..rollover_val and returns to 0
// on the enabled cycle after reaching rollover_val; rollover_flag marks the
// terminal value.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_d, count_q;

  // Next count: clear wins, then increment or return to zero at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rcv_ctrl.sv
// UART receive control: synchronizes the line, detects the start bit,
// confirms it at mid-start-bit, strobes the shift register at each mid-bit,
// then checks the received stop bit for one cycle.
module rcv_ctrl
  import rcv_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int NUM_BITS     = NUM_BITS_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  rcv_ctrl_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

  logic       sync1_d, sync1_q;
  logic       sync2_d, sync2_q;
  logic       prev_d, prev_q;
  rcv_state_t state_d, state_q;
  logic       framing_error_d, framing_error_q;

  logic          start_edge;
  logic          shift_strobe;
  logic          load_buffer;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_roll;
  logic          tmr_clear;
  logic          tmr_en;
  logic [BW-1:0] bit_cnt;
  logic          bit_last;

  // Bit-period timer: held at zero in IDLE, restarted after the start-bit check,
  // and wraps by itself at the end of each data bit period.
  assign tmr_clear = (state_q == IDLE) || ((state_q == START_CHK) && (tmr_cnt == HALF_M1));
  assign tmr_en    = (state_q == START_CHK) || (state_q == RECV);

  flex_counter #(.NUM_CNT_BITS(CW)) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (tmr_clear),
    .count_enable  (tmr_en),
    .rollover_val  (FULL_M1),
    .count_out     (tmr_cnt),
    .rollover_flag (tmr_roll)
  );

  // Bit counter: one step per strobe; its terminal flag marks the final strobe.
  flex_counter #(.NUM_CNT_BITS(BW)) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state_q == IDLE),
    .count_enable  (shift_strobe),
    .rollover_val  (LAST_BIT),
    .count_out     (bit_cnt),
    .rollover_flag (bit_last)
  );

  // Two-flop synchronizer followed by a one-flop history for falling-edge detect.
  always_comb begin
    sync1_d = bus.serial_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign start_edge = prev_q & ~sync2_q;

  // State, synchronizer and sticky framing flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      prev_q          <= 1'b1;
      state_q         <= IDLE;
      framing_error_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      state_q         <= state_d;
      framing_error_q <= framing_error_d;
    end
  end

  // Next-state logic; framing_error clears on an accepted start, sets on a bad stop.
  always_comb begin
    state_d         = state_q;
    framing_error_d = framing_error_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d         = START_CHK;
          framing_error_d = 1'b0;
        end
      end
      START_CHK: begin
        if (tmr_cnt == HALF_M1) begin
          state_d = sync2_q ? IDLE : RECV;
        end
      end
      RECV: begin
        if (shift_strobe && bit_last) begin
          state_d = STOP_CHK;
        end
      end
      STOP_CHK: begin
        state_d = IDLE;
        if (!bus.stop_bit) begin
          framing_error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state and counters.
  always_comb begin
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    case (state_q)
      RECV:     shift_strobe = tmr_roll;
      STOP_CHK: load_buffer  = bus.stop_bit;
      default:  ;
    endcase
  end

  assign bus.serial_sync   = sync2_q;
  assign bus.shift_strobe  = shift_strobe;
  assign bus.load_buffer   = load_buffer;
  assign bus.framing_error = framing_error_q;
  assign bus.rx_busy       = (state_q != IDLE);
  assign bus.dbg           = '{state: state_q, clk_cnt: 8'(tmr_cnt), bit_cnt: 8'(bit_cnt)};

endmodule

// File: tb/tb_rcv_ctrl.sv
// Bench for rcv_ctrl: drives serial frames, models the downstream 9-bit shift
// register, and scores strobe timing, frame outcome and flags from a queue of
// expectations computed when each frame is sent.
module tb_rcv_ctrl;
  import rcv_pkg::*;

  localparam int CPB = 10;
  localparam int NB  = 9;
  // Raw line to serial_sync latency, so a raw fall drives start_edge this many clocks later.
  localparam int SYNC_LAT = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [8:0]  sr;

  logic [31:0] exp_strobe_q[$];
  logic [40:0] exp_frame_q[$];
  logic        fe_chk_pending = 1'b0;
  logic        fe_chk_val = 1'b0;

  rcv_ctrl_if bus();

  rcv_ctrl #(.CLKS_PER_BIT(CPB), .NUM_BITS(NB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 9-bit receive shift register: LSB-first, stop bit ends up in the MSB.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr <= '0;
    else if (bus.shift_strobe) sr <= {bus.serial_sync, sr[8:1]};
  end
  assign bus.stop_bit = sr[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an event, required none (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the line high for n clocks.
  task automatic idle(input int n);
    bus.serial_in = 1'b1;
    repeat (n) step();
  endtask

  // Drive the first nbits bit periods of a frame (start, 8 data, stop) and
  // queue the strobes and frame end that must follow from them.
  task automatic send(input logic [7:0] data, input logic stop, input int nbits);
    logic [9:0] bits;
    int d;
    int first;
    bits  = {stop, data, 1'b0};
    d     = int'(cyc);
    first = d + SYNC_LAT + CPB / 2 + CPB;
    for (int i = 0; i < NB; i++)
      if (i < nbits - 1) exp_strobe_q.push_back(32'(first + CPB * i));
    if (nbits == 10)
      exp_frame_q.push_back({32'(first + CPB * (NB - 1) + 1), stop, data});
    for (int j = 0; j < CPB * nbits; j++) begin
      bus.serial_in = bits[j / CPB];
      if (j == SYNC_LAT + 1) begin
        check("fe_clear_on_start", bus.framing_error, 1'b0);
        check("busy_after_start", bus.rx_busy, 1'b1);
      end
      step();
    end
  endtask

  // Three-clock low pulse: rejected at the start-bit check, busy for exactly 5 clocks.
  task automatic glitch();
    int busy_cycles;
    busy_cycles = 0;
    bus.serial_in = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (j == 3) begin
        bus.serial_in = 1'b1;
        check("glitch_fe_clear", bus.framing_error, 1'b0);
      end
      if (bus.rx_busy) busy_cycles++;
      step();
    end
    check("glitch_busy_cycles", 64'(busy_cycles), 64'd5);
    check("glitch_back_idle", bus.dbg.state, IDLE);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_serial_sync"}, bus.serial_sync, 1'b1);
    check({tag, "_shift_strobe"}, bus.shift_strobe, 1'b0);
    check({tag, "_load_buffer"}, bus.load_buffer, 1'b0);
    check({tag, "_framing_error"}, bus.framing_error, 1'b0);
    check({tag, "_rx_busy"}, bus.rx_busy, 1'b0);
    check({tag, "_state"}, bus.dbg.state, IDLE);
    check({tag, "_counters"}, {bus.dbg.clk_cnt, bus.dbg.bit_cnt}, 16'h0);
  endtask

  // Monitor: pops expectations whenever the DUT strobes or finishes a frame.
  always @(negedge clk) begin
    logic [40:0] e;
    if (n_rst) begin
      if (fe_chk_pending) begin
        check("framing_error_after_stop", bus.framing_error, fe_chk_val);
        fe_chk_pending <= 1'b0;
      end
      if (bus.shift_strobe) begin
        if (exp_strobe_q.size() == 0) fail_now("unexpected_strobe");
        else check("strobe_cycle", 64'(cyc), 64'(exp_strobe_q.pop_front()));
      end
      if (bus.load_buffer) check("strobe_load_overlap", bus.shift_strobe, 1'b0);
      if (bus.dbg.state == STOP_CHK) begin
        if (exp_frame_q.size() == 0) begin
          fail_now("unexpected_frame_end");
        end else begin
          e = exp_frame_q.pop_front();
          check("frame_end_cycle", 64'(cyc), 64'(e[40:9]));
          check("load_buffer", bus.load_buffer, e[8]);
          check("packet_data", sr[7:0], e[7:0]);
          fe_chk_pending <= 1'b1;
          fe_chk_val     <= ~e[8];
        end
      end else if (bus.load_buffer) begin
        fail_now("load_outside_stop_check");
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [7:0] data;
    logic       stop;
    bus.serial_in = 1'b1;
    n_rst = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    n_rst = 1'b1;
    step();
    check("idle_after_reset", bus.dbg.state, IDLE);

    // Good frame, then a bad-stop frame whose flag must persist through idle.
    send(8'hA5, 1'b1, 10);
    idle(20);
    send(8'h3C, 1'b0, 10);
    idle(40);
    check("fe_sticky", bus.framing_error, 1'b1);

    glitch();
    idle(10);

    // Reset after the fourth strobe, then a clean frame.
    send(8'hF0, 1'b1, 5);
    n_rst = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    exp_strobe_q.delete();
    exp_frame_q.delete();
    bus.serial_in = 1'b1;
    repeat (3) step();
    n_rst = 1'b1;
    idle(5);
    send(8'h5A, 1'b1, 10);
    idle(5);

    // Back-to-back frames with no idle gap.
    send(8'hFF, 1'b1, 10);
    send(8'h00, 1'b1, 10);
    idle(5);

    // Bad stop, then a good frame that clears the flag.
    send(8'h55, 1'b0, 10);
    idle(3);
    send(8'h81, 1'b1, 10);
    idle(5);

    // Random frames with random gaps (a low stop bit needs a high gap before the next start).
    for (int k = 0; k < 25; k++) begin
      data = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send(data, stop, 10);
      idle(int'($urandom_range(stop ? 0 : 1, 12)));
    end

    idle(150);
    check("strobes_outstanding", 64'(exp_strobe_q.size()), 64'd0);
    check("frames_outstanding", 64'(exp_frame_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
